// File: rtl/vga_board_pkg.sv
// Shared definitions for the board mark renderer: cell-state codes and active video limits.
package vga_board_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_state_e;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

endpackage

// File: rtl/vga_mark_shape.sv
// Combinational X / O shape test on absolute offsets from a cell centre.
module vga_mark_shape #(
    parameter int RAD_X  = 70,
    parameter int RAD_Y  = 70,
    parameter int RAD_D  = 100,
    parameter int STROKE = 20
) (
    input  logic [10:0] ax,
    input  logic [10:0] ay,
    output logic        is_x_shape,
    output logic        is_o_shape
);

    int   x, y, diff;
    logic box, inner;

    always_comb begin
        x    = int'(ax);
        y    = int'(ay);
        diff = (x >= y) ? x - y : y - x;
        // Octagon: box clipped by an |dx|+|dy| chamfer; the O is the outer minus the inner.
        box   = (x <= RAD_X) && (y <= RAD_Y) && (x + y <= RAD_D);
        inner = (x <= RAD_X - STROKE) && (y <= RAD_Y - STROKE) && (x + y <= RAD_D - STROKE);
        is_o_shape = box && !inner;
        is_x_shape = box && (diff <= STROKE / 2);
    end

endmodule

// File: rtl/vga_board_marks.sv
// Two-stage pixel pipeline rendering X/O marks for a whole board, with a grow-in
// animation on the most recently placed mark and blinking of the winning cells.
module vga_board_marks
    import vga_board_pkg::*;
#(
    parameter int unsigned ROWS         = 3,
    parameter int unsigned COLS         = 3,
    parameter int unsigned ORG_X        = 40,
    parameter int unsigned ORG_Y        = 0,
    parameter int unsigned CELL_W       = 200,
    parameter int unsigned CELL_H       = 160,
    parameter int unsigned STROKE       = 20,
    parameter int unsigned RAD_X        = 70,
    parameter int unsigned RAD_Y        = 70,
    parameter int unsigned RAD_D        = 100,
    parameter int unsigned GROW_STEPS   = 8,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [10:0]              hc,
    input  logic [10:0]              vc,
    input  logic                     blank,
    input  logic                     frame_start,
    input  logic [2*ROWS*COLS-1:0]   cell_state,
    input  logic [ROWS*COLS-1:0]     win_mask,
    input  logic                     place_stb,
    input  logic [3:0]               place_idx,
    output logic                     fig_x,
    output logic                     fig_o,
    output logic                     anim_busy
);

    localparam int unsigned NCells = ROWS * COLS;
    localparam int unsigned ScaleW = $clog2(GROW_STEPS + 1);
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [3:0]        col, row_base, idx_d, idx_q;
    logic [10:0]       cx, cy, ax_d, ax_q, ay_d, ay_q;
    logic              in_board_d, in_board_q, blank_q;

    logic [3:0]        anim_idx_d, anim_idx_q;
    logic [ScaleW-1:0] scale_d, scale_q;
    logic              anim_busy_d, anim_busy_q;
    logic [10:0]       clip_x_d, clip_x_q, clip_y_d, clip_y_q;
    logic [BlinkW-1:0] blink_cnt_d, blink_cnt_q;
    logic              blink_phase_d, blink_phase_q;

    logic              shape_x, shape_o, clipped, visible, show;
    logic [1:0]        cs;
    logic [NCells-1:0] win_sh;
    logic              fig_x_d, fig_x_q, fig_o_d, fig_o_q;

    // S1: the last boundary passed in each axis selects the cell and its centre.
    always_comb begin
        col = '0;
        cx  = 11'(ORG_X + CELL_W / 2);
        for (int c = 1; c < COLS; c++) begin
            if (hc >= 11'(ORG_X + c * CELL_W)) begin
                col = 4'(c);
                cx  = 11'(ORG_X + c * CELL_W + CELL_W / 2);
            end
        end
        row_base = '0;
        cy       = 11'(ORG_Y + CELL_H / 2);
        for (int r = 1; r < ROWS; r++) begin
            if (vc >= 11'(ORG_Y + r * CELL_H)) begin
                row_base = 4'(r * COLS);
                cy       = 11'(ORG_Y + r * CELL_H + CELL_H / 2);
            end
        end
        // Offset compare in 12 bits: coordinates left of/above the origin wrap high.
        in_board_d = (({1'b0, hc} - 12'(ORG_X)) < 12'(COLS * CELL_W)) &&
                     (({1'b0, vc} - 12'(ORG_Y)) < 12'(ROWS * CELL_H)) &&
                     (hc < 11'(H_ACTIVE)) && (vc < 11'(V_ACTIVE));
        idx_d = row_base + col;
        ax_d  = (hc >= cx) ? hc - cx : cx - hc;
        ay_d  = (vc >= cy) ? vc - cy : cy - vc;
    end

    // Grow-in and blink state; clip radii only move on frame_start.
    always_comb begin
        anim_idx_d    = anim_idx_q;
        scale_d       = scale_q;
        anim_busy_d   = anim_busy_q;
        clip_x_d      = clip_x_q;
        clip_y_d      = clip_y_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (frame_start && (scale_q < ScaleW'(GROW_STEPS))) begin
            scale_d = scale_q + ScaleW'(1);
            if (scale_d == ScaleW'(GROW_STEPS)) anim_busy_d = 1'b0;
        end
        if (place_stb && ({1'b0, place_idx} < 5'(NCells))) begin
            anim_idx_d  = place_idx;
            scale_d     = ScaleW'(1);
            anim_busy_d = (GROW_STEPS > 1);
        end
        if (frame_start) begin
            for (int s = 0; s <= GROW_STEPS; s++) begin
                if (scale_d == ScaleW'(s)) begin
                    clip_x_d = 11'((RAD_X * s) / GROW_STEPS);
                    clip_y_d = 11'((RAD_Y * s) / GROW_STEPS);
                end
            end
        end

        if (win_mask == '0) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_start) begin
            if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BlinkW'(1);
            end
        end
    end

    vga_mark_shape #(
        .RAD_X (RAD_X),
        .RAD_Y (RAD_Y),
        .RAD_D (RAD_D),
        .STROKE(STROKE)
    ) u_shape (
        .ax        (ax_q),
        .ay        (ay_q),
        .is_x_shape(shape_x),
        .is_o_shape(shape_o)
    );

    // S2: shape, cell contents and visibility gating.
    always_comb begin
        cs      = 2'(cell_state >> {idx_q, 1'b0});
        win_sh  = win_mask >> idx_q;
        clipped = (idx_q == anim_idx_q) && anim_busy_q &&
                  ((ax_q > clip_x_q) || (ay_q > clip_y_q));
        visible = !(win_sh[0] && blink_phase_q) && !clipped;
        show    = in_board_q && !blank_q && visible;
        fig_x_d = show && shape_x && (cs == MARK_X);
        fig_o_d = show && shape_o && (cs == MARK_O);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            ax_q          <= '0;
            ay_q          <= '0;
            in_board_q    <= 1'b0;
            blank_q       <= 1'b1;
            anim_idx_q    <= '0;
            scale_q       <= ScaleW'(GROW_STEPS);
            anim_busy_q   <= 1'b0;
            clip_x_q      <= 11'(RAD_X);
            clip_y_q      <= 11'(RAD_Y);
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            fig_x_q       <= 1'b0;
            fig_o_q       <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            ax_q          <= ax_d;
            ay_q          <= ay_d;
            in_board_q    <= in_board_d;
            blank_q       <= blank;
            anim_idx_q    <= anim_idx_d;
            scale_q       <= scale_d;
            anim_busy_q   <= anim_busy_d;
            clip_x_q      <= clip_x_d;
            clip_y_q      <= clip_y_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            fig_x_q       <= fig_x_d;
            fig_o_q       <= fig_o_d;
        end
    end

    assign fig_x     = fig_x_q;
    assign fig_o     = fig_o_q;
    assign anim_busy = anim_busy_q;

endmodule

// File: tb/tb_vga_board_marks.sv
// Self-checking bench for vga_board_marks: fixed vectors, corner sequences and a random run.
module tb_vga_board_marks;

    localparam int ROWS = 3, COLS = 3, ORG_X = 40, ORG_Y = 0, CELL_W = 200, CELL_H = 160;
    localparam int STROKE = 20, RAD_X = 70, RAD_Y = 70, RAD_D = 100;
    localparam int GROW = 8, BLINK = 2;
    localparam int N = ROWS * COLS;
    localparam int CSW = 2 * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [10:0]    hc = '0, vc = '0;
    logic           blank = 1'b1, frame_start = 1'b0, place_stb = 1'b0;
    logic [3:0]     place_idx = '0;
    logic [CSW-1:0] cell_state = '0;
    logic [N-1:0]   win_mask = '0;
    logic           fig_x, fig_o, anim_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: the animation/blink status as plain integers, plus the
    // pixel presented one clock earlier (the one whose result appears after the next edge).
    int m_scale, m_anim, m_clip_x, m_clip_y, m_cnt;
    bit m_busy, m_phase;
    int p_hc, p_vc;
    bit p_blank;

    typedef struct {
        int             h;
        int             v;
        bit             b;
        logic [CSW-1:0] cs;
        logic           ex;
        logic           eo;
    } vec_t;
    vec_t vecs[14];

    int cidx, dx, dy;

    vga_board_marks #(
        .ROWS(ROWS), .COLS(COLS), .ORG_X(ORG_X), .ORG_Y(ORG_Y),
        .CELL_W(CELL_W), .CELL_H(CELL_H), .STROKE(STROKE),
        .RAD_X(RAD_X), .RAD_Y(RAD_Y), .RAD_D(RAD_D),
        .GROW_STEPS(GROW), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hc         (hc),
        .vc         (vc),
        .blank      (blank),
        .frame_start(frame_start),
        .cell_state (cell_state),
        .win_mask   (win_mask),
        .place_stb  (place_stb),
        .place_idx  (place_idx),
        .fig_x      (fig_x),
        .fig_o      (fig_o),
        .anim_busy  (anim_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_scale  = GROW;
        m_anim   = 0;
        m_busy   = 0;
        m_clip_x = RAD_X;
        m_clip_y = RAD_Y;
        m_cnt    = 0;
        m_phase  = 0;
        p_hc     = 0;
        p_vc     = 0;
        p_blank  = 1;
    endfunction

    // Returns {x, o} for the previously presented pixel under the current model state.
    function automatic logic [1:0] model_pixel();
        int col, row, idx, ax, ay, cs, d;
        bit box, inner, vis;
        logic [CSW-1:0] sh;
        if (p_blank || p_hc < ORG_X || p_hc >= ORG_X + COLS * CELL_W ||
            p_vc < ORG_Y || p_vc >= ORG_Y + ROWS * CELL_H) return 2'b00;
        col = (p_hc - ORG_X) / CELL_W;
        row = (p_vc - ORG_Y) / CELL_H;
        idx = row * COLS + col;
        ax  = p_hc - (ORG_X + col * CELL_W + CELL_W / 2);
        ay  = p_vc - (ORG_Y + row * CELL_H + CELL_H / 2);
        if (ax < 0) ax = -ax;
        if (ay < 0) ay = -ay;
        d     = (ax > ay) ? ax - ay : ay - ax;
        box   = ax <= RAD_X && ay <= RAD_Y && ax + ay <= RAD_D;
        inner = ax <= RAD_X - STROKE && ay <= RAD_Y - STROKE && ax + ay <= RAD_D - STROKE;
        sh    = cell_state >> (2 * idx);
        cs    = int'(sh[1:0]);
        vis   = !(win_mask[idx] && m_phase) &&
                !(idx == m_anim && m_busy && (ax > m_clip_x || ay > m_clip_y));
        return {box && d <= STROKE / 2 && vis && cs == 1, box && !inner && vis && cs == 2};
    endfunction

    function automatic void model_step();
        if (place_stb && int'(place_idx) < N) begin
            m_anim  = int'(place_idx);
            m_scale = 1;
            m_busy  = (GROW > 1);
        end else if (frame_start && m_scale < GROW) begin
            m_scale++;
            if (m_scale == GROW) m_busy = 0;
        end
        if (frame_start) begin
            m_clip_x = RAD_X * m_scale / GROW;
            m_clip_y = RAD_Y * m_scale / GROW;
        end
        if (win_mask == '0) begin
            m_cnt   = 0;
            m_phase = 0;
        end else if (frame_start) begin
            if (m_cnt == BLINK - 1) begin
                m_cnt   = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
        p_hc    = int'(hc);
        p_vc    = int'(vc);
        p_blank = blank;
    endfunction

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: predict, clock, step the model, compare all three outputs.
    task automatic tick(input string name);
        logic [1:0] exp_px;
        exp_px = model_pixel();
        @(posedge clk);
        model_step();
        #1;
        checks++;
        if ({fig_x, fig_o, anim_busy} !== {exp_px, m_busy}) begin
            errors++;
            $display("FAIL %s: got x/o/busy=%b%b%b, expected %b%b%b (t=%0t)",
                     name, fig_x, fig_o, anim_busy, exp_px[1], exp_px[0], m_busy, $time);
        end
        frame_start = 1'b0;
        place_stb   = 1'b0;
    endtask

    task automatic idle();
        hc    = '0;
        vc    = '0;
        blank = 1'b1;
    endtask

    task automatic show(input string name, input int h, input int v, input bit b,
                        input logic ex, input logic eo);
        hc    = 11'(h);
        vc    = 11'(v);
        blank = b;
        tick(name);
        idle();
        tick(name);
        check({name, "/x"}, fig_x, ex);
        check({name, "/o"}, fig_o, eo);
    endtask

    task automatic frame();
        idle();
        frame_start = 1'b1;
        tick("frame");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        frame_start = 1'b0;
        place_stb   = 1'b0;
        win_mask    = '0;
        cell_state  = '0;
        idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{210, 80, 1'b0, 18'h00002, 1'b0, 1'b1};
        vecs[1]  = '{140, 80, 1'b0, 18'h00002, 1'b0, 1'b0};
        vecs[2]  = '{340, 240, 1'b0, 18'h00100, 1'b1, 1'b0};
        vecs[3]  = '{370, 290, 1'b0, 18'h00100, 1'b0, 1'b0};
        vecs[4]  = '{340, 240, 1'b1, 18'h00100, 1'b0, 1'b0};
        vecs[5]  = '{20, 80, 1'b0, 18'h15555, 1'b0, 1'b0};
        vecs[6]  = '{540, 470, 1'b0, 18'h20000, 1'b0, 1'b1};
        vecs[7]  = '{590, 450, 1'b0, 18'h20000, 1'b0, 1'b1};
        vecs[8]  = '{591, 450, 1'b0, 18'h20000, 1'b0, 1'b0};
        vecs[9]  = '{140, 80, 1'b0, 18'h00003, 1'b0, 1'b0};
        vecs[10] = '{585, 125, 1'b0, 18'h00010, 1'b1, 1'b0};
        vecs[11] = '{610, 150, 1'b0, 18'h00010, 1'b0, 1'b0};
        vecs[12] = '{340, 240, 1'b0, 18'h20000, 1'b0, 1'b0};
        vecs[13] = '{340, 270, 1'b0, 18'h00100, 1'b0, 1'b0};

        model_reset();
        #3;
        check("reset_fig_x", fig_x, 1'b0);
        check("reset_fig_o", fig_o, 1'b0);
        check("reset_busy", anim_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cell_state = vecs[i].cs;
            show($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].b, vecs[i].ex, vecs[i].eo);
        end

        // Grow-in on cell 4.
        do_reset();
        cell_state = 18'h00100;
        place_idx  = 4'd4;
        place_stb  = 1'b1;
        tick("grow_place");
        check("grow_busy_set", anim_busy, 1'b1);
        frame();
        show("grow_f1_outer", 380, 280, 1'b0, 1'b0, 1'b0);
        show("grow_f1_inner", 345, 245, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 5; f++) frame();
        check("grow_busy_f6", anim_busy, 1'b1);
        frame();
        check("grow_busy_f7", anim_busy, 1'b0);
        show("grow_full", 380, 280, 1'b0, 1'b1, 1'b0);

        // Place coinciding with frame_start, then a restart on another cell.
        do_reset();
        cell_state  = 18'h00101;
        place_idx   = 4'd4;
        place_stb   = 1'b1;
        frame_start = 1'b1;
        idle();
        tick("same_cycle");
        show("scale1_out", 349, 240, 1'b0, 1'b0, 1'b0);
        show("scale1_in", 348, 240, 1'b0, 1'b1, 1'b0);
        place_idx = 4'd0;
        place_stb = 1'b1;
        tick("restart");
        show("old_cell_full", 380, 280, 1'b0, 1'b1, 1'b0);
        show("new_cell_clip", 180, 120, 1'b0, 1'b0, 1'b0);
        check("restart_busy", anim_busy, 1'b1);
        place_idx = 4'd12;
        place_stb = 1'b1;
        tick("bad_idx");
        show("bad_idx_old", 380, 280, 1'b0, 1'b1, 1'b0);
        show("bad_idx_new", 180, 120, 1'b0, 1'b0, 1'b0);

        // Blink on cells 0,3,6 with 2-frame half period.
        do_reset();
        cell_state = 18'h00005;
        win_mask   = 9'b001_001_001;
        idle();
        tick("blink_arm");
        for (int f = 1; f <= 6; f++) begin
            frame();
            show($sformatf("blink_f%0d_win", f), 140, 80, 1'b0, ((f / 2) % 2) == 0, 1'b0);
            show($sformatf("blink_f%0d_other", f), 340, 80, 1'b0, 1'b1, 1'b0);
        end
        win_mask = '0;
        show("blink_cleared", 140, 80, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-line.
        do_reset();
        cell_state = 18'h0000A;
        win_mask   = 9'b000_000_001;
        place_idx  = 4'd4;
        place_stb  = 1'b1;
        tick("rst_place");
        frame();
        frame();
        show("rst_pre_hidden", 210, 80, 1'b0, 1'b0, 1'b0);
        hc    = 11'd410;
        vc    = 11'd80;
        blank = 1'b0;
        tick("rst_pix");
        idle();
        tick("rst_pix");
        check("rst_pre_o", fig_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_o", fig_o, 1'b0);
        check("rst_async_busy", anim_busy, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        hc    = 11'd410;
        vc    = 11'd80;
        blank = 1'b0;
        tick("rst_release");
        check("rst_first_pix", fig_o, 1'b0);
        idle();
        tick("rst_second");
        show("rst_phase_cleared", 210, 80, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 40 == 0) cell_state = CSW'($urandom);
            if (i % 300 == 0) win_mask = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                cidx = int'($urandom_range(0, N - 1));
                dx   = int'($urandom_range(0, 160)) - 80;
                dy   = int'($urandom_range(0, 160)) - 80;
                hc   = 11'(ORG_X + (cidx % COLS) * CELL_W + CELL_W / 2 + dx);
                vc   = 11'(ORG_Y + (cidx / COLS) * CELL_H + CELL_H / 2 + dy);
            end else begin
                hc = 11'($urandom_range(0, 700));
                vc = 11'($urandom_range(0, 520));
            end
            blank       = ($urandom_range(0, 9) == 0);
            frame_start = ($urandom_range(0, 29) == 0);
            place_stb   = ($urandom_range(0, 79) == 0);
            place_idx   = 4'($urandom_range(0, 15));
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
